seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: Seq_Divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port CLK_I, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST_I, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port START_I, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port A_I, input, WIDTH bits: unsigned dividend, captured on the accepting edge.
REQ-006 The block SHALL have port B_I, input, WIDTH bits: unsigned divisor, captured on the accepting edge.
REQ-007 The block SHALL have port Q_O, output, WIDTH bits: quotient.
REQ-008 The block SHALL have port R_O, output, WIDTH bits: remainder.
REQ-009 The block SHALL have port BUSY_O, output, 1 bit: high in RUN and DONE states.
REQ-010 The block SHALL have port DONE_O, output, 1 bit: one-cycle pulse marking Q_O/R_O valid.
REQ-011 The block SHALL have port DIV0_O, output, 1 bit: divide-by-zero flag, valid with DONE_O.

Function
REQ-012 The block SHALL implement a restoring shift-subtract divider with states IDLE, RUN, DONE.
REQ-013 IDLE with START_I=1 at an edge SHALL capture A_I, B_I, clear partial remainder, load iteration counter with WIDTH, and enter RUN.
REQ-014 Each RUN edge SHALL shift {remainder, dividend} left one bit, subtract the divisor from the remainder using a WIDTH+1-bit difference, keep the difference and set quotient bit to 1 if non-negative, else restore and set 0.
REQ-015 RUN SHALL perform exactly WIDTH iterations, entering DONE on the edge of the final iteration.
REQ-016 DONE_O SHALL be high for exactly the one cycle spent in DONE, i.e. the cycle after the WIDTH-th edge following acceptance; the next edge SHALL return to IDLE unconditionally.
REQ-017 Q_O and R_O SHALL satisfy A = Q*B + R with R < B for B != 0, and SHALL hold their values from DONE until the next accepted START_I.
REQ-018 START_I high in RUN or DONE SHALL be ignored, with no queuing; back-to-back requests need START_I held or reasserted in IDLE.
REQ-019 A_I/B_I changes after the accepting edge SHALL NOT affect the result in progress.
REQ-020 Divide by zero SHALL produce Q_O all ones and R_O = dividend; this is the natural result of REQ-014.

Reset
REQ-021 RST_I high SHALL immediately force IDLE and clear Q_O, R_O, BUSY_O, DONE_O, DIV0_O and the counter to 0, regardless of clock.
REQ-022 Reset mid-RUN SHALL abandon the operation without a DONE_O pulse; the first START_I accepted after release SHALL start a fresh division.

Configuration
REQ-023 Macro DIV0_DETECT_EN SHALL select early divide-by-zero detection.
REQ-024 With DIV0_DETECT_EN defined, B_I=0 at acceptance SHALL skip RUN and go directly to DONE with Q_O all ones, R_O = A_I and DIV0_O=1, so DONE_O is high in the cycle after the accepting edge; DIV0_O SHALL clear on the next accepted START_I.
REQ-025 Without DIV0_DETECT_EN, DIV0_O SHALL be tied to 0 and B=0 SHALL run the full WIDTH iterations per REQ-020.

Verification
REQ-026 WIDTH=8, A=100, B=7 -> Q_O=14, R_O=2, DIV0_O=0, DONE_O single pulse 8 edges after acceptance, BUSY_O high for 9 cycles.
REQ-027 A=255, B=1 -> Q_O=255, R_O=0. A=3, B=200 -> Q_O=0, R_O=3.
REQ-028 A=77, B=0 -> Q_O=255, R_O=77; with DIV0_DETECT_EN: DIV0_O=1 and DONE_O 1 edge after acceptance; without it: DIV0_O=0 and DONE_O after 8 edges.
REQ-029 START_I held high through a division with A_I/B_I toggled -> result matches captured operands, second division starts on the first IDLE edge.
REQ-030 RST_I pulsed asynchronously (mid-cycle) at iteration 4 -> all outputs 0 immediately, no DONE_O; subsequent A=50, B=6 -> Q_O=8, R_O=2.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider -- sequential restoring shift-subtract unsigned divider.
//
// One quotient bit is produced per clock, so a division finishes WIDTH
// edges after it is accepted.  The result then stays on Q_O/R_O until the
// next accepted request.
//
// Parameters:
//   WIDTH    operand and result width in bits (2..32), default 8
//
// Ports:
//   CLK_I    clock; all state changes on the rising edge
//   RST_I    asynchronous active-high reset; returns to IDLE, clears outputs
//   START_I  division request, sampled only while idle
//   A_I      unsigned dividend, captured on the accepting edge
//   B_I      unsigned divisor, captured on the accepting edge
//   Q_O      quotient
//   R_O      remainder
//   BUSY_O   high while a division is running or its result is being flagged
//   DONE_O   one-cycle pulse marking Q_O/R_O valid
//   DIV0_O   divide-by-zero flag, valid with DONE_O
//
// Build option:
//   DIV0_DETECT_EN  when defined, a zero divisor skips the iterations and
//                   the result is flagged one cycle after acceptance with
//                   DIV0_O set.  When undefined, DIV0_O is tied low and a
//                   zero divisor runs all WIDTH iterations.  That run
//                   naturally gives an all-ones quotient and a remainder
//                   equal to the dividend.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             START_I,
  input  logic [WIDTH-1:0] A_I,
  input  logic [WIDTH-1:0] B_I,
  output logic [WIDTH-1:0] Q_O,
  output logic [WIDTH-1:0] R_O,
  output logic             BUSY_O,
  output logic             DONE_O,
  output logic             DIV0_O
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [CW-1:0] CNT_STEP = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // One restoring step.  quo_q initially holds the dividend.  Each step
  // shifts its top bit into the remainder, and the new quotient bit fills
  // the vacated LSB.  The trial subtraction is decided on the full
  // WIDTH+1-bit shifted remainder.  When it fits, the true difference is
  // below the divisor, so the low WIDTH bits of the subtraction are exact.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    fits     = (shifted >= {1'b0, div_q});
    rem_next = fits ? (shifted[WIDTH-1:0] - div_q) : shifted[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], fits};
  end

`ifdef DIV0_DETECT_EN
  logic div0_q;
`endif

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= IDLE;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
`ifdef DIV0_DETECT_EN
      div0_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (START_I) begin
            div_q <= B_I;
            rem_q <= '0;
            quo_q <= A_I;
            cnt_q <= CNT_LOAD;
            state <= RUN;
`ifdef DIV0_DETECT_EN
            div0_q <= (B_I == '0);
            // Zero divisor: load the known result directly and flag it next cycle
            if (B_I == '0) begin
              rem_q <= A_I;
              quo_q <= '1;
              cnt_q <= '0;
              state <= DONE;
            end
`endif
          end
        end
        RUN: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q - CNT_STEP;
          // The edge that performs the last iteration also leaves RUN
          if (cnt_q == CNT_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign Q_O    = quo_q;
  assign R_O    = rem_q;
  assign BUSY_O = (state == RUN) || (state == DONE);
  assign DONE_O = (state == DONE);

`ifdef DIV0_DETECT_EN
  assign DIV0_O = div0_q;
`else
  assign DIV0_O = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider -- self-checking bench for seq_divider at WIDTH = 8.
// Latency here is the number of clock edges after the accepting edge
// until DONE_O is seen high.
module tb_seq_divider;

  localparam int W = 8;

`ifdef DIV0_DETECT_EN
  localparam bit DETECT = 1'b1;
`else
  localparam bit DETECT = 1'b0;
`endif

  logic         CLK_I = 1'b0;
  logic         RST_I;
  logic         START_I;
  logic [W-1:0] A_I;
  logic [W-1:0] B_I;
  logic [W-1:0] Q_O;
  logic [W-1:0] R_O;
  logic         BUSY_O;
  logic         DONE_O;
  logic         DIV0_O;

  int testsRun  = 0;
  int failCount = 0;

  always #5 CLK_I = ~CLK_I;

  seq_divider #(.WIDTH(W)) dut (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .START_I(START_I),
    .A_I    (A_I),
    .B_I    (B_I),
    .Q_O    (Q_O),
    .R_O    (R_O),
    .BUSY_O (BUSY_O),
    .DONE_O (DONE_O),
    .DIV0_O (DIV0_O)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issue one request, scramble the operand inputs right after acceptance,
  // then wait (bounded) for DONE_O and one more edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               output logic [W-1:0] q, output logic [W-1:0] r,
                               output logic dz, output int lat,
                               output int busyCnt, output logic pulseOne);
    @(negedge CLK_I);
    START_I = 1'b1;
    A_I     = a;
    B_I     = b;
    @(posedge CLK_I);
    #1;
    START_I = 1'b0;
    A_I     = W'($urandom);
    B_I     = W'($urandom);
    lat     = 0;
    busyCnt = 0;
    if (BUSY_O) busyCnt++;
    while (!DONE_O && lat < 40) begin
      @(posedge CLK_I);
      #1;
      lat++;
      if (BUSY_O) busyCnt++;
    end
    q  = Q_O;
    r  = R_O;
    dz = DIV0_O;
    @(posedge CLK_I);
    #1;
    pulseOne = !DONE_O && !BUSY_O;
  endtask

  // Run one division and compare against expectations derived from the
  // divider's arithmetic contract.
  task automatic runDivide(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eq,
                           input logic [W-1:0] er);
    logic [W-1:0] q, r;
    logic dz, pulseOne;
    int lat, busyCnt, expLat;
    bit early;
    early  = DETECT && (b == 0);
    expLat = early ? 0 : W;
    applyStimulus(a, b, q, r, dz, lat, busyCnt, pulseOne);
    checkOutput({tag, "_q"}, 32'(q), 32'(eq));
    checkOutput({tag, "_r"}, 32'(r), 32'(er));
    checkOutput({tag, "_div0"}, 32'(dz), 32'(early));
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'(expLat + 1));
    checkOutput({tag, "_single_pulse"}, 32'(pulseOne), 32'd1);
    checkOutput({tag, "_hold_q"}, 32'(Q_O), 32'(eq));
    checkOutput({tag, "_hold_r"}, 32'(R_O), 32'(er));
  endtask

  initial begin
    logic [W-1:0] a, b, eq, er;
    int lat;
    bit sawDone;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0};
    vecs[2] = '{a: 8'd3,   b: 8'd200, q: 8'd0,   r: 8'd3};
    vecs[3] = '{a: 8'd77,  b: 8'd0,   q: 8'd255, r: 8'd77};
    vecs[4] = '{a: 8'd50,  b: 8'd6,   q: 8'd8,   r: 8'd2};
    vecs[5] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0};
    vecs[6] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0};
    vecs[7] = '{a: 8'd200, b: 8'd3,   q: 8'd66,  r: 8'd2};
    vecs[8] = '{a: 8'd128, b: 8'd16,  q: 8'd8,   r: 8'd0};

    RST_I   = 1'b0;
    START_I = 1'b0;
    A_I     = '0;
    B_I     = '0;
    #1;
    RST_I = 1'b1;
    #20;
    checkOutput("reset_q", 32'(Q_O), 32'd0);
    checkOutput("reset_r", 32'(R_O), 32'd0);
    checkOutput("reset_busy", 32'(BUSY_O), 32'd0);
    checkOutput("reset_done", 32'(DONE_O), 32'd0);
    checkOutput("reset_div0", 32'(DIV0_O), 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b0;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      runDivide($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
    end

    // Randomized operands against plain-arithmetic reference
    for (int i = 0; i < 25; i++) begin
      a = W'($urandom);
      b = (i % 7 == 0) ? '0 : W'($urandom);
      eq = (b == 0) ? '1 : a / b;
      er = (b == 0) ? a : a % b;
      runDivide($sformatf("rand%0d_%0d_%0d", i, a, b), a, b, eq, er);
    end

    // START held through a division while operands toggle; second request
    // must be taken on the first idle edge.
    @(negedge CLK_I);
    START_I = 1'b1;
    A_I     = 8'd20;
    B_I     = 8'd3;
    @(posedge CLK_I);
    #1;
    lat = 0;
    while (!DONE_O && lat < 40) begin
      @(negedge CLK_I);
      A_I = W'($urandom);
      B_I = W'($urandom);
      @(posedge CLK_I);
      #1;
      lat++;
    end
    checkOutput("b2b_first_q", 32'(Q_O), 32'd6);
    checkOutput("b2b_first_r", 32'(R_O), 32'd2);
    checkOutput("b2b_first_latency", 32'(lat), 32'(W));
    @(negedge CLK_I);
    A_I = 8'd90;
    B_I = 8'd9;
    @(posedge CLK_I);
    #1;
    checkOutput("b2b_idle_gap_busy", 32'(BUSY_O), 32'd0);
    @(posedge CLK_I);
    #1;
    checkOutput("b2b_second_accepted", 32'(BUSY_O), 32'd1);
    START_I = 1'b0;
    lat = 0;
    while (!DONE_O && lat < 40) begin
      @(posedge CLK_I);
      #1;
      lat++;
    end
    checkOutput("b2b_second_q", 32'(Q_O), 32'd10);
    checkOutput("b2b_second_r", 32'(R_O), 32'd0);
    checkOutput("b2b_second_latency", 32'(lat), 32'(W));
    @(posedge CLK_I);
    #1;

    // Asynchronous reset in the middle of the run
    @(negedge CLK_I);
    START_I = 1'b1;
    A_I     = 8'd100;
    B_I     = 8'd7;
    @(posedge CLK_I);
    #1;
    START_I = 1'b0;
    repeat (4) begin
      @(posedge CLK_I);
      #1;
    end
    #2;
    RST_I = 1'b1;
    #1;
    checkOutput("midreset_q", 32'(Q_O), 32'd0);
    checkOutput("midreset_r", 32'(R_O), 32'd0);
    checkOutput("midreset_busy", 32'(BUSY_O), 32'd0);
    checkOutput("midreset_done", 32'(DONE_O), 32'd0);
    checkOutput("midreset_div0", 32'(DIV0_O), 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    sawDone = 1'b0;
    repeat (12) begin
      @(posedge CLK_I);
      #1;
      if (DONE_O) sawDone = 1'b1;
    end
    checkOutput("midreset_no_done", 32'(sawDone), 32'd0);
    runDivide("after_reset", 8'd50, 8'd6, 8'd8, 8'd2);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
